// File: rtl/bs_rr_arbiter_bcast_if.sv
// ---------------------------------------------------------------------------
// bs_rr_arbiter_bcast_if
// Packet bus between the arbiter and its FIFO-backed agents.
//
// Signals (drvrs agents, pckg_sz bits per packet):
//   pndng  [drvrs]           per-agent FIFO non-empty flag
//   D_pop  [drvrs*pckg_sz]   per-agent FIFO head data, agent i at [i*pckg_sz +: pckg_sz]
//   pop    [drvrs]           one-hot pop strobe back to the source FIFO
//   push   [drvrs]           push strobe(s) to the destination FIFO(s)
//   D_push [drvrs*pckg_sz]   delivered packet, replicated into every agent slice
//
// Modports:
//   master : the arbiter side (reads requests/data, drives strobes/data)
//   slave  : the agent side (drives requests/data, reads strobes/data)
// ---------------------------------------------------------------------------
interface bs_rr_arbiter_bcast_if #(
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);

    logic [drvrs-1:0]         pndng;
    logic [drvrs*pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]         pop;
    logic [drvrs-1:0]         push;
    logic [drvrs*pckg_sz-1:0] D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );

endinterface

// File: rtl/bs_rr_arbiter_bcast.sv
// ---------------------------------------------------------------------------
// bs_rr_arbiter_bcast
// Shared packet bus arbiter for drvrs FIFO-backed agents. Each transaction
// arbitrates among agents with pending packets (round-robin or fixed
// priority), pops the winner's head packet and delivers it to the agent
// selected by the packet's ID field, to every other agent on the broadcast
// ID, or drops it when the ID names no agent.
//
// Parameters:
//   drvrs     number of agents (2..16)
//   pckg_sz   packet width in bits
//   id_w      destination ID width, ID = packet[pckg_sz-1 -: id_w]
//   broadcast ID value meaning "all agents except the source"
//   arb_mode  0 = round-robin, 1 = fixed priority (lowest index wins)
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   agents    packet bus (master modport): pndng, D_pop in; pop, push, D_push out
//   busy      high whenever the FSM is not in IDLE
//   grant_id  index of the current or last granted agent
//   pkt_cnt   delivered packet count, wraps, a broadcast counts once
//   drop_cnt  dropped packet count, saturates at 8'hFF
// ---------------------------------------------------------------------------
module bs_rr_arbiter_bcast #(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter int              id_w      = 8,
    parameter logic [id_w-1:0] broadcast = {id_w{1'b1}},
    parameter int              arb_mode  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    bs_rr_arbiter_bcast_if.master    agents,
    output logic                     busy,
    output logic [$clog2(drvrs)-1:0] grant_id,
    output logic [15:0]              pkt_cnt,
    output logic [7:0]               drop_cnt
);

    localparam int GW = $clog2(drvrs);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic [GW-1:0]        r_rrPtr;
    logic [GW-1:0]        r_grant;
    logic [pckg_sz-1:0]   r_pkt;
    logic [pckg_sz-1:0]   r_dpush;
    logic [drvrs-1:0]     r_pop;
    logic [drvrs-1:0]     r_push;
    logic                 r_busy;
    logic [15:0]          r_pktCnt;
    logic [7:0]           r_dropCnt;

    logic [GW-1:0]        w_nextPtr;
    logic [GW-1:0]        w_nextGrant;
    logic [pckg_sz-1:0]   w_nextPkt;
    logic [pckg_sz-1:0]   w_nextDpush;
    logic [drvrs-1:0]     w_nextPop;
    logic [drvrs-1:0]     w_nextPush;
    logic [15:0]          w_nextPktCnt;
    logic [7:0]           w_nextDropCnt;

    logic [GW-1:0]        w_win;
    logic [GW-1:0]        w_idx;
    logic                 w_found;
    logic [pckg_sz-1:0]   w_head;
    logic [drvrs-1:0]     w_popVec;
    logic [drvrs-1:0]     w_uniVec;
    logic [drvrs-1:0]     w_bcVec;
    logic [id_w-1:0]      w_dest;

    assign w_dest = r_pkt[pckg_sz-1 -: id_w];

    // Winner selection. Round-robin scans upward starting one past the last
    // grant and wraps modulo drvrs, so the agent just served is tried last.
    // Fixed priority simply takes the lowest pending index.
    always_comb begin
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (arb_mode == 1) begin
            for (int k = 0; k < drvrs; k++) begin
                if (!w_found && agents.pndng[k]) begin
                    w_win   = GW'(k);
                    w_found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= drvrs; k++) begin
                w_idx = GW'((int'(r_rrPtr) + k) % drvrs);
                if (!w_found && agents.pndng[w_idx]) begin
                    w_win   = w_idx;
                    w_found = 1'b1;
                end
            end
        end
    end

    // Per-agent decode done with constant indices: the winner's head data and
    // its pop bit, the unicast destination bit, and the broadcast mask that
    // excludes the source agent.
    always_comb begin
        w_head   = '0;
        w_popVec = '0;
        w_uniVec = '0;
        w_bcVec  = '0;
        for (int k = 0; k < drvrs; k++) begin
            if (w_win == GW'(k)) begin
                w_head      = agents.D_pop[k*pckg_sz +: pckg_sz];
                w_popVec[k] = 1'b1;
            end
            w_uniVec[k] = (w_dest == id_w'(k));
            w_bcVec[k]  = (r_grant != GW'(k));
        end
    end

    // Next-state and next-output logic. All outputs are registered, so the
    // strobe that belongs to a state is computed on the edge entering it:
    // pop is loaded leaving IDLE so it is high throughout POP, push and the
    // counters are loaded leaving POP so they show up during PUSH.
    always_comb begin
        w_nextState   = r_state;
        w_nextPtr     = r_rrPtr;
        w_nextGrant   = r_grant;
        w_nextPkt     = r_pkt;
        w_nextDpush   = r_dpush;
        w_nextPop     = '0;
        w_nextPush    = '0;
        w_nextPktCnt  = r_pktCnt;
        w_nextDropCnt = r_dropCnt;
        case (r_state)
            IDLE: begin
                if (|agents.pndng) begin
                    w_nextState = POP;
                    w_nextPtr   = w_win;
                    w_nextGrant = w_win;
                    w_nextPkt   = w_head;
                    w_nextPop   = w_popVec;
                end
            end
            POP: begin
                w_nextState = PUSH;
                w_nextDpush = r_pkt;
                if (w_dest == broadcast) begin
                    w_nextPush   = w_bcVec;
                    w_nextPktCnt = r_pktCnt + 16'd1;
                end else if (|w_uniVec) begin
                    w_nextPush   = w_uniVec;
                    w_nextPktCnt = r_pktCnt + 16'd1;
                end else if (r_dropCnt != 8'hFF) begin
                    w_nextDropCnt = r_dropCnt + 8'd1;
                end
            end
            PUSH: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State and output registers. The reset pointer of drvrs-1 makes the
    // very first round-robin search start at agent 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_rrPtr   <= GW'(drvrs - 1);
            r_grant   <= '0;
            r_pkt     <= '0;
            r_dpush   <= '0;
            r_pop     <= '0;
            r_push    <= '0;
            r_busy    <= 1'b0;
            r_pktCnt  <= '0;
            r_dropCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_rrPtr   <= w_nextPtr;
            r_grant   <= w_nextGrant;
            r_pkt     <= w_nextPkt;
            r_dpush   <= w_nextDpush;
            r_pop     <= w_nextPop;
            r_push    <= w_nextPush;
            r_busy    <= (w_nextState != IDLE);
            r_pktCnt  <= w_nextPktCnt;
            r_dropCnt <= w_nextDropCnt;
        end
    end

    assign agents.pop    = r_pop;
    assign agents.push   = r_push;
    assign agents.D_push = {drvrs{r_dpush}};
    assign busy          = r_busy;
    assign grant_id      = r_grant;
    assign pkt_cnt       = r_pktCnt;
    assign drop_cnt      = r_dropCnt;

endmodule

// File: tb/tb_bs_rr_arbiter_bcast.sv
// ---------------------------------------------------------------------------
// tb_bs_rr_arbiter_bcast
// Drives two arbiters (round-robin and fixed priority) with directed packet
// vectors. Expected transactions are queued when stimulus is issued; a monitor
// pops an entry whenever a pop strobe appears and checks the following push
// cycle against it.
// ---------------------------------------------------------------------------
module tb_bs_rr_arbiter_bcast;

    typedef struct {
        int          sel;
        logic [3:0]  pop;
        logic [1:0]  grant;
        logic [3:0]  push;
        logic [15:0] data;
        logic [15:0] pktCnt;
        logic [7:0]  dropCnt;
        int          gap;
    } txn_t;

    logic clk;
    logic reset;

    bs_rr_arbiter_bcast_if #(.drvrs(4), .pckg_sz(16)) if0 ();
    bs_rr_arbiter_bcast_if #(.drvrs(4), .pckg_sz(16)) if1 ();

    logic        busyV  [2];
    logic [1:0]  grantV [2];
    logic [15:0] pktV   [2];
    logic [7:0]  dropV  [2];
    logic [3:0]  popV   [2];
    logic [3:0]  pushV  [2];
    logic [63:0] dpushV [2];

    txn_t expQ[$];
    txn_t cur[2];
    int   havePush[2];
    int   popsSeen[2];
    int   lastPop[2];
    int   cycle;
    int   nChecks;
    int   nFails;

    bs_rr_arbiter_bcast #(.drvrs(4), .pckg_sz(16), .id_w(8), .broadcast(8'hFF), .arb_mode(0)) dutRr (
        .clk      (clk),
        .reset    (reset),
        .agents   (if0),
        .busy     (busyV[0]),
        .grant_id (grantV[0]),
        .pkt_cnt  (pktV[0]),
        .drop_cnt (dropV[0])
    );

    bs_rr_arbiter_bcast #(.drvrs(4), .pckg_sz(16), .id_w(8), .broadcast(8'hFF), .arb_mode(1)) dutFix (
        .clk      (clk),
        .reset    (reset),
        .agents   (if1),
        .busy     (busyV[1]),
        .grant_id (grantV[1]),
        .pkt_cnt  (pktV[1]),
        .drop_cnt (dropV[1])
    );

    assign popV[0]   = if0.pop;
    assign popV[1]   = if1.pop;
    assign pushV[0]  = if0.push;
    assign pushV[1]  = if1.push;
    assign dpushV[0] = if0.D_push;
    assign dpushV[1] = if1.D_push;

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure spacing between pops
    always @(posedge clk) cycle <= cycle + 1;

    // One counted comparison; prints a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pushExp(input int sel, input logic [3:0] pop, input logic [1:0] grant,
                           input logic [3:0] push, input logic [15:0] data,
                           input logic [15:0] pktCnt, input logic [7:0] dropCnt, input int gap);
        txn_t t;
        t.sel = sel; t.pop = pop; t.grant = grant; t.push = push; t.data = data;
        t.pktCnt = pktCnt; t.dropCnt = dropCnt; t.gap = gap;
        expQ.push_back(t);
    endtask

    task automatic drive(input int sel, input logic [3:0] req, input logic [63:0] dpop);
        if (sel == 0) begin
            if0.pndng = req;
            if0.D_pop = dpop;
        end else begin
            if1.pndng = req;
            if1.D_pop = dpop;
        end
    endtask

    // Present requests, wait (bounded) for n pops, then switch to afterReq
    task automatic applyStimulus(input int sel, input logic [3:0] req, input logic [63:0] dpop,
                                 input int n, input logic [3:0] afterReq);
        int target;
        int budget;
        target = popsSeen[sel] + n;
        budget = 6 * n + 10;
        drive(sel, req, dpop);
        while (popsSeen[sel] < target && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        checkOutput("popsServed", 64'(popsSeen[sel]), 64'(target));
        drive(sel, afterReq, dpop);
    endtask

    task automatic checkReset();
        for (int s = 0; s < 2; s++) begin
            checkOutput("rstPop",   64'(popV[s]),   64'd0);
            checkOutput("rstPush",  64'(pushV[s]),  64'd0);
            checkOutput("rstDpush", dpushV[s],      64'd0);
            checkOutput("rstBusy",  64'(busyV[s]),  64'd0);
            checkOutput("rstGrant", 64'(grantV[s]), 64'd0);
            checkOutput("rstPkt",   64'(pktV[s]),   64'd0);
            checkOutput("rstDrop",  64'(dropV[s]),  64'd0);
        end
    endtask

    task automatic waitIdle();
        repeat (4) @(negedge clk);
    endtask

    // Monitor: on each pop strobe take the next expected transaction and check
    // the pop cycle; on the cycle after, check push, data and counters.
    initial begin
        havePush[0] = 0; havePush[1] = 0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (havePush[s] != 0) begin
                    checkOutput("push",    64'(pushV[s]), 64'(cur[s].push));
                    checkOutput("dPush",   dpushV[s],     {4{cur[s].data}});
                    checkOutput("pktCnt",  64'(pktV[s]),  64'(cur[s].pktCnt));
                    checkOutput("dropCnt", 64'(dropV[s]), 64'(cur[s].dropCnt));
                    checkOutput("busyPush", 64'(busyV[s]), 64'd1);
                    havePush[s] = 0;
                end else if (pushV[s] != 4'b0000) begin
                    checkOutput("strayPush", 64'(pushV[s]), 64'd0);
                end
                if (popV[s] != 4'b0000) begin
                    if (expQ.size() == 0) begin
                        checkOutput("strayPop", 64'(popV[s]), 64'd0);
                    end else begin
                        cur[s] = expQ.pop_front();
                        checkOutput("dutSel", 64'(s), 64'(cur[s].sel));
                        checkOutput("pop",    64'(popV[s]),   64'(cur[s].pop));
                        checkOutput("grant",  64'(grantV[s]), 64'(cur[s].grant));
                        checkOutput("pushDuringPop", 64'(pushV[s]), 64'd0);
                        if (cur[s].gap > 0)
                            checkOutput("popGap", 64'(cycle - lastPop[s]), 64'(cur[s].gap));
                        havePush[s] = 1;
                    end
                    lastPop[s] = cycle;
                    popsSeen[s]++;
                end
            end
        end
    end

    initial begin
        logic [3:0]  rrPush [4];
        logic [63:0] rrData;
        int          dropExp;
        nChecks = 0; nFails = 0; cycle = 0;
        popsSeen[0] = 0; popsSeen[1] = 0;
        lastPop[0] = 0; lastPop[1] = 0;
        reset = 1'b0;
        drive(0, 4'b0000, 64'd0);
        drive(1, 4'b0000, 64'd0);

        // Reset held for 3 cycles, then released
        repeat (3) @(negedge clk);
        checkReset();
        reset = 1'b1;
        @(negedge clk);
        checkReset();

        // Unicast from agent 1 to agent 2
        pushExp(0, 4'b0010, 2'd1, 4'b0100, 16'h02AB, 16'd1, 8'd0, 0);
        applyStimulus(0, 4'b0010, {16'h0000, 16'h0000, 16'h02AB, 16'h0000}, 1, 4'b0000);
        waitIdle();

        // Broadcast from agent 0 reaches everyone but agent 0
        pushExp(0, 4'b0001, 2'd0, 4'b1110, 16'hFF55, 16'd2, 8'd0, 0);
        applyStimulus(0, 4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hFF55}, 1, 4'b0000);
        waitIdle();

        // Fixed priority: agent 1 starves agent 3 until it stops requesting
        for (int k = 0; k < 3; k++)
            pushExp(1, 4'b0010, 2'd1, 4'b0001, 16'h0011, 16'(k + 1), 8'd0, (k == 0) ? 0 : 3);
        pushExp(1, 4'b1000, 2'd3, 4'b0100, 16'h0233, 16'd4, 8'd0, 3);
        applyStimulus(1, 4'b1010, {16'h0233, 16'h0000, 16'h0011, 16'h0000}, 3, 4'b1000);
        applyStimulus(1, 4'b1000, {16'h0233, 16'h0000, 16'h0011, 16'h0000}, 1, 4'b0000);
        waitIdle();

        // Fresh reset so the round-robin pointer starts from agent 0 again
        reset = 1'b0;
        @(negedge clk);
        checkReset();
        reset = 1'b1;
        @(negedge clk);

        // Round-robin with all four agents requesting; agent 2 addresses itself
        rrPush[0] = 4'b0010;
        rrPush[1] = 4'b0100;
        rrPush[2] = 4'b0100;
        rrPush[3] = 4'b0001;
        rrData = {16'h0033, 16'h0222, 16'h0211, 16'h0100};
        for (int k = 0; k < 8; k++)
            pushExp(0, 4'(1 << (k % 4)), 2'(k % 4), rrPush[k % 4], rrData[(k % 4) * 16 +: 16],
                    16'(k + 1), 8'd0, (k == 0) ? 0 : 3);
        applyStimulus(0, 4'b1111, rrData, 8, 4'b0000);
        waitIdle();

        // Invalid destination 0x07 is dropped without touching pkt_cnt
        pushExp(0, 4'b0001, 2'd0, 4'b0000, 16'h0711, 16'd8, 8'd1, 0);
        applyStimulus(0, 4'b0001, {48'd0, 16'h0711}, 1, 4'b0000);
        waitIdle();

        // 299 further drops: drop_cnt saturates at 8'hFF
        for (int k = 2; k <= 300; k++) begin
            dropExp = (k > 255) ? 255 : k;
            pushExp(0, 4'b0001, 2'd0, 4'b0000, 16'h0711, 16'd8, 8'(dropExp), (k == 2) ? 0 : 3);
        end
        applyStimulus(0, 4'b0001, {48'd0, 16'h0711}, 299, 4'b0000);
        waitIdle();

        // Reset asserted during PUSH clears strobes and counters at once
        pushExp(0, 4'b0001, 2'd0, 4'b0100, 16'h0299, 16'd9, 8'hFF, 0);
        applyStimulus(0, 4'b0001, {48'd0, 16'h0299}, 1, 4'b0000);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midRstPush",  64'(pushV[0]), 64'd0);
        checkOutput("midRstPkt",   64'(pktV[0]),  64'd0);
        checkOutput("midRstDrop",  64'(dropV[0]), 64'd0);
        checkOutput("midRstBusy",  64'(busyV[0]), 64'd0);
        checkOutput("midRstDpush", dpushV[0],     64'd0);
        @(negedge clk);
        reset = 1'b1;
        waitIdle();

        checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
